// File: rtl/exc_ctrl_multi_if.sv
// exc_ctrl_multi_if: core-side bundle of the multi-source exception controller.
interface exc_ctrl_multi_if #(
    parameter int N    = 64,
    parameter int NSRC = 4,
    parameter int ST_W = 4
);
    logic [NSRC-1:0] exc_req;
    logic [NSRC-1:0] exc_mask;
    logic [ST_W-1:0] estatus;
    logic            eret;
    logic [N-1:0]    next_pc;
    logic [N-1:0]    imem_addr;
    logic [N-1:0]    pc_branch_in;
    logic [1:0]      mrs_sel;
    logic            exc_take;
    logic [N-1:0]    exc_vector;
    logic [NSRC-1:0] exc_ack;
    logic            in_handler;
    logic [N-1:0]    pc_branch_out;
    logic [N-1:0]    mrs_data;
    logic            spurious_eret;

    modport master (
        output exc_req, exc_mask, estatus, eret, next_pc, imem_addr, pc_branch_in, mrs_sel,
        input  exc_take, exc_vector, exc_ack, in_handler, pc_branch_out, mrs_data, spurious_eret
    );
    modport slave (
        input  exc_req, exc_mask, estatus, eret, next_pc, imem_addr, pc_branch_in, mrs_sel,
        output exc_take, exc_vector, exc_ack, in_handler, pc_branch_out, mrs_data, spurious_eret
    );
endinterface

// File: rtl/exc_ctrl_multi.sv
// exc_ctrl_multi: vectored multi-source exception controller with saved ERR/ELR/ESR,
// handler residency tracking and a saturating taken-exception counter.
module exc_ctrl_multi #(
    parameter int             N          = 64,
    parameter int             NSRC       = 4,
    parameter int             ST_W       = 4,
    parameter logic [N-1:0]   VEC_BASE   = 64'hD8,
    parameter logic [N-1:0]   VEC_STRIDE = 64'h20,
    parameter int             CNT_W      = 16
) (
    input  logic      clk,
    input  logic      reset,
    exc_ctrl_multi_if.slave bus
);
    localparam int IW = $clog2(NSRC);

    typedef enum logic {IDLE, HANDLER} state_t;

    state_t           state;
    logic [NSRC-1:0]  pending;
    logic [NSRC-1:0]  eligible;
    logic [NSRC-1:0]  ack;
    logic [IW-1:0]    idx;
    logic             take;
    logic [N-1:0]     err;
    logic [N-1:0]     elr;
    logic [ST_W+IW-1:0] esr;
    logic [CNT_W-1:0] cnt;
    logic             spurious;

    // descending scan so the lowest eligible index wins
    always_comb begin
        eligible = pending & ~bus.exc_mask;
        idx = '0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (eligible[i]) idx = IW'(i);
        take = state == IDLE && |eligible && !bus.eret;
        ack = take ? NSRC'(1) << idx : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            pending  <= '0;
            err      <= '0;
            elr      <= '0;
            esr      <= '0;
            cnt      <= '0;
            spurious <= 1'b0;
        end else begin
            pending <= bus.exc_req | (pending & ~ack);
            if (take) begin
                err   <= bus.next_pc;
                elr   <= bus.imem_addr;
                esr   <= {idx, bus.estatus};
                cnt   <= &cnt ? cnt : cnt + CNT_W'(1);
                state <= HANDLER;
            end
            if (bus.eret) begin
                if (state == IDLE) spurious <= 1'b1;
                else state <= IDLE;
            end
        end
    end

    assign bus.exc_take      = take;
    assign bus.exc_ack       = ack;
    assign bus.exc_vector    = |eligible ? VEC_BASE + N'(idx) * VEC_STRIDE : '0;
    assign bus.in_handler    = state == HANDLER;
    assign bus.pc_branch_out = bus.eret ? err : bus.pc_branch_in;
    assign bus.spurious_eret = spurious;
    assign bus.mrs_data      = bus.mrs_sel == 2'd0 ? err :
                               bus.mrs_sel == 2'd1 ? elr :
                               bus.mrs_sel == 2'd2 ? N'(esr) : N'(cnt);
endmodule

// File: tb/tb_exc_ctrl_multi.sv
// tb_exc_ctrl_multi: directed checks of exc_ctrl_multi; a second instance with a
// 2-bit counter shares all stimulus to exercise counter saturation.
module tb_exc_ctrl_multi;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    exc_ctrl_multi_if #(.N(64), .NSRC(4), .ST_W(4)) bus_a ();
    exc_ctrl_multi_if #(.N(64), .NSRC(4), .ST_W(4)) bus_b ();

    exc_ctrl_multi dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    exc_ctrl_multi #(.CNT_W(2)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    assign bus_b.exc_req      = bus_a.exc_req;
    assign bus_b.exc_mask     = bus_a.exc_mask;
    assign bus_b.estatus      = bus_a.estatus;
    assign bus_b.eret         = bus_a.eret;
    assign bus_b.next_pc      = bus_a.next_pc;
    assign bus_b.imem_addr    = bus_a.imem_addr;
    assign bus_b.pc_branch_in = bus_a.pc_branch_in;
    assign bus_b.mrs_sel      = bus_a.mrs_sel;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus_a.exc_req = 4'hF;
        bus_a.exc_mask = '0;
        bus_a.estatus = '0;
        bus_a.eret = 1'b0;
        bus_a.next_pc = '0;
        bus_a.imem_addr = '0;
        bus_a.pc_branch_in = '0;
        bus_a.mrs_sel = 2'd3;
        cyc;
        cyc;
        #1;
        check("rst_take", 64'(bus_a.exc_take), 64'd0);
        check("rst_ack", 64'(bus_a.exc_ack), 64'd0);
        check("rst_inh", 64'(bus_a.in_handler), 64'd0);
        check("rst_cnt", bus_a.mrs_data, 64'd0);
        check("rst_spur", 64'(bus_a.spurious_eret), 64'd0);
        check("rst_vec", bus_a.exc_vector, 64'd0);
        reset = 1'b1;
        #1;
        check("rel_take_pre", 64'(bus_a.exc_take), 64'd0);
        cyc;
        #1;
        check("rel_take", 64'(bus_a.exc_take), 64'd1);
        check("rel_ack", 64'(bus_a.exc_ack), 64'h1);
        check("rel_vec", bus_a.exc_vector, 64'hD8);
        reset = 1'b0;
        bus_a.exc_req = '0;
        #1;
        check("async_take", 64'(bus_a.exc_take), 64'd0);
        cyc;
        reset = 1'b1;

        // single take from source 2
        bus_a.exc_req = 4'b0100;
        bus_a.imem_addr = 64'h100;
        bus_a.next_pc = 64'h104;
        bus_a.estatus = 4'h3;
        cyc;
        bus_a.exc_req = '0;
        #1;
        check("s_take", 64'(bus_a.exc_take), 64'd1);
        check("s_vec", bus_a.exc_vector, 64'h118);
        check("s_ack", 64'(bus_a.exc_ack), 64'b0100);
        cyc;
        check("s_inh", 64'(bus_a.in_handler), 64'd1);
        bus_a.mrs_sel = 2'd0; #1 check("s_err", bus_a.mrs_data, 64'h104);
        bus_a.mrs_sel = 2'd1; #1 check("s_elr", bus_a.mrs_data, 64'h100);
        bus_a.mrs_sel = 2'd2; #1 check("s_esr", bus_a.mrs_data, 64'h23);
        bus_a.mrs_sel = 2'd3; #1 check("s_cnt", bus_a.mrs_data, 64'd1);
        bus_a.eret = 1'b1;
        bus_a.pc_branch_in = 64'h555;
        #1;
        check("s_eret_pc", bus_a.pc_branch_out, 64'h104);
        cyc;
        bus_a.eret = 1'b0;
        #1;
        check("s_idle", 64'(bus_a.in_handler), 64'd0);
        check("s_pc_pass", bus_a.pc_branch_out, 64'h555);
        check("s_spur", 64'(bus_a.spurious_eret), 64'd0);

        // priority and mask
        bus_a.exc_req = 4'b1010;
        bus_a.exc_mask = 4'b0010;
        cyc;
        bus_a.exc_req = '0;
        #1;
        check("p_take", 64'(bus_a.exc_take), 64'd1);
        check("p_vec", bus_a.exc_vector, 64'h138);
        check("p_ack", 64'(bus_a.exc_ack), 64'b1000);
        cyc;
        check("p_inh", 64'(bus_a.in_handler), 64'd1);
        check("p_take_h", 64'(bus_a.exc_take), 64'd0);
        bus_a.mrs_sel = 2'd2; #1 check("p_esr", bus_a.mrs_data, 64'h33);
        bus_a.eret = 1'b1;
        #1;
        check("p_eret_pc", bus_a.pc_branch_out, 64'h104);
        cyc;
        bus_a.eret = 1'b0;
        #1;
        check("p_masked", 64'(bus_a.exc_take), 64'd0);
        check("p_idle", 64'(bus_a.in_handler), 64'd0);
        cyc;
        bus_a.exc_mask = '0;
        bus_a.imem_addr = 64'h200;
        bus_a.next_pc = 64'h204;
        #1;
        check("p_unmask_take", 64'(bus_a.exc_take), 64'd1);
        check("p_unmask_vec", bus_a.exc_vector, 64'hF8);
        check("p_unmask_ack", 64'(bus_a.exc_ack), 64'b0010);
        cyc;
        bus_a.mrs_sel = 2'd3;
        #1;
        check("p_cnt_a", bus_a.mrs_data, 64'd3);
        check("p_cnt_b", bus_b.mrs_data, 64'd3);

        // no nesting while in the handler
        bus_a.exc_req = 4'b0001;
        cyc;
        bus_a.exc_req = '0;
        #1;
        check("n_take", 64'(bus_a.exc_take), 64'd0);
        check("n_ack", 64'(bus_a.exc_ack), 64'd0);
        check("n_inh", 64'(bus_a.in_handler), 64'd1);
        bus_a.eret = 1'b1;
        #1;
        check("n_eret_pc", bus_a.pc_branch_out, 64'h204);
        check("n_eret_take", 64'(bus_a.exc_take), 64'd0);
        cyc;
        bus_a.eret = 1'b0;
        #1;
        check("n_take_after", 64'(bus_a.exc_take), 64'd1);
        check("n_ack_after", 64'(bus_a.exc_ack), 64'b0001);
        check("n_vec_after", bus_a.exc_vector, 64'hD8);
        cyc;
        check("n_cnt_a", bus_a.mrs_data, 64'd4);
        check("n_cnt_b", bus_b.mrs_data, 64'd3);
        bus_a.eret = 1'b1;
        cyc;
        bus_a.eret = 1'b0;

        // spurious ERET after a mid-cycle reset pulse
        reset = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        bus_a.exc_req = 4'b0001;
        cyc;
        bus_a.exc_req = '0;
        bus_a.eret = 1'b1;
        bus_a.pc_branch_in = 64'h777;
        bus_a.mrs_sel = 2'd0;
        #1;
        check("sp_take", 64'(bus_a.exc_take), 64'd0);
        check("sp_pc", bus_a.pc_branch_out, 64'd0);
        check("sp_err", bus_a.mrs_data, 64'd0);
        cyc;
        bus_a.eret = 1'b0;
        #1;
        check("sp_flag", 64'(bus_a.spurious_eret), 64'd1);
        check("sp_take_next", 64'(bus_a.exc_take), 64'd1);
        cyc;
        cyc;
        check("sp_sticky", 64'(bus_a.spurious_eret), 64'd1);
        reset = 1'b0;
        bus_a.mrs_sel = 2'd3;
        #1;
        check("sp_clear", 64'(bus_a.spurious_eret), 64'd0);
        check("sp_inh_clear", 64'(bus_a.in_handler), 64'd0);
        check("sp_cnt_clear", bus_a.mrs_data, 64'd0);
        cyc;
        reset = 1'b1;

        // five takes: wide counter counts, 2-bit counter saturates
        for (int k = 0; k < 5; k++) begin
            bus_a.exc_req = 4'b0001;
            cyc;
            bus_a.exc_req = '0;
            #1;
            check($sformatf("sat_take%0d", k), 64'(bus_a.exc_take), 64'd1);
            cyc;
            bus_a.eret = 1'b1;
            cyc;
            bus_a.eret = 1'b0;
        end
        #1;
        check("sat_cnt_b", bus_b.mrs_data, 64'd3);
        check("sat_cnt_a", bus_a.mrs_data, 64'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/exc_ctrl_multi.md
Name: exc_ctrl_multi

Overview:
- Multi-source, vectored exception controller for the LEGv8 single-cycle core. Successor to the single-source exception unit.
- Latches up to NSRC exception requests into per-source pending bits, masks them, and takes the highest-priority one.
- On take: saves ERR/ELR/ESR, redirects fetch to a per-source vector, and tracks handler residency until ERET.
- Exposes the saved state, plus a taken-exception counter, to MRS through a read mux.

Parameters:
N, 64, datapath/PC width
NSRC, 4, number of exception sources (2..16); index 0 = highest priority
ST_W, 4, width of per-exception status field
VEC_BASE, 64'hD8, vector address of source 0
VEC_STRIDE, 64'h20, byte spacing between consecutive source vectors
CNT_W, 16, width of taken-exception counter

Ports:
clk  in  1  core clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
exc_req  in  NSRC  per-source request; level, sampled each clock
exc_mask  in  NSRC  1 = source masked (stays pending, not taken)
estatus  in  ST_W  status code of the instruction in Execute, captured on take
eret  in  1  ERET decoded in Execute
next_pc  in  N  PC+4 of the current instruction
imem_addr  in  N  PC of the current instruction
pc_branch_in  in  N  normal branch target
mrs_sel  in  2  0 ERR, 1 ELR, 2 ESR, 3 counter
exc_take  out  1  redirect fetch to exc_vector this cycle
exc_vector  out  N  VEC_BASE + idx*VEC_STRIDE of the winning source
exc_ack  out  NSRC  one-hot, 1-cycle pulse to the taken source
in_handler  out  1  handler active (state HANDLER)
pc_branch_out  out  N  err when eret=1, else pc_branch_in
mrs_data  out  N  selected saved register, zero-extended
spurious_eret  out  1  sticky: ERET seen in IDLE

Behaviour:
- Reset (reset=0, asynchronous): pending=0, state=IDLE, ERR=ELR=0, ESR=0, cnt=0, spurious_eret=0.
  - Comb outputs then: exc_take=0, exc_ack=0, in_handler=0.
  - Reset mid-handler discards all state; no return is pending.
- Pending: at each edge, pending[i] <= exc_req[i] | (pending[i] & ~ack[i]).
  - A request still high in the ack cycle re-pends on the next edge. Sources must drop exc_req on seeing exc_ack.
- Eligible = pending & ~exc_mask. Winner idx = lowest set bit of eligible.
- FSM states IDLE, HANDLER.
  - IDLE, eligible!=0, eret=0: exc_take=1 and exc_ack[idx]=1 combinationally, with exc_vector valid.
    - At the edge: ERR<=next_pc, ELR<=imem_addr, ESR<={idx, estatus}, cnt<=cnt+1 (saturating at all-ones), state<=HANDLER.
  - IDLE, eret=1: pc_branch_out=ERR, spurious_eret<=1, no take that cycle even if eligible. Stay IDLE.
  - HANDLER: exc_take=0. New requests accumulate as pending (no nesting). in_handler=1.
    - eret=1: pc_branch_out=ERR and state<=IDLE. A pending eligible exception is taken on the following cycle (1-cycle gap).
- exc_vector is driven from idx whenever eligible!=0, and is 0 when none are eligible.
- Arithmetic is N-bit and wraps on the vector add.
- ESR layout: [ST_W+IW-1:ST_W]=idx, [ST_W-1:0]=estatus, with IW=$clog2(NSRC).
- mrs_data is fully combinational from the registers; a take is visible on the cycle after the edge.
- Masking a pending source never clears it. Unmasking makes it eligible in the same cycle.

Test Plan:
- Reset: hold reset=0 for 2 cycles with exc_req=4'hF -> all outputs 0, cnt=0. Release, and exc_take=1 is asserted the cycle after the first sampling edge.
- Single take:
  - Stimulus: exc_req[2] pulse, imem_addr=0x100, next_pc=0x104, estatus=4'h3.
  - exc_take=1, exc_vector=0xD8+2*0x20=0x118, exc_ack=4'b0100.
  - Next cycle in_handler=1. mrs_sel=0/1/2/3 -> 0x104 / 0x100 / 0x23 / 1.
- Priority and mask:
  - Stimulus: exc_req=4'b1010 same cycle, exc_mask=4'b0010.
  - Source 3 is taken (vector 0x138) and source 1 stays pending.
  - ERET, then unmask: source 1 is taken 2 cycles after the ERET, with vector 0xF8.
- No nesting: exc_req[0] raised while in HANDLER -> exc_take stays 0. On ERET, pc_branch_out=saved ERR, then source 0 is taken the next cycle.
- Spurious ERET in IDLE: pc_branch_out=ERR(0) and spurious_eret=1 and stays 1, until reset=0 asynchronously clears it mid-cycle.
- Counter saturation with CNT_W=2: take 5 exceptions -> mrs_sel=3 reads 3.
